md_unit: RTL
============

Name: md_unit

Overview:
- Multiply/divide unit with its own sequencer, placed in the EX stage beside the ALU.
- Executes mult/multu/div/divu over a fixed multi-cycle latency, and executes mthi/mtlo in a single cycle.
- Holds the architectural HI/LO registers, which feed the mfhi/mflo data path.
- Raises a stall request to the bypass/hazard unit so that MDU-dependent instructions wait in ID until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (range 1..15)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  EX-stage instruction is an MDU operation (one-cycle pulse per instruction)
- op  in  3  MDU opcode: MD_MULT=0, MD_MULTU=1, MD_DIV=2, MD_DIVU=3, MD_MTHI=4, MD_MTLO=5; values 6..7 are no-ops
- src_a  in  32  forwarded rs value in EX
- src_b  in  32  forwarded rt value in EX
- md_use_d  in  1  ID-stage instruction is any of mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- hi  out  32  HI register
- lo  out  32  LO register
- busy  out  1  multi-cycle operation in progress
- stall_req  out  1  request to the hazard unit to stall PC/IF_ID and flush ID_EX

Behaviour:
- Reset (sync, high): state=IDLE, cnt=0, hi=0, lo=0, busy=0, operand/opcode latches cleared. Reset overrides an operation in progress; any partial result is discarded.
- States: IDLE, RUN.
- IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}:
  - Latch src_a, src_b and op.
  - Load cnt = MULT_CYCLES or DIV_CYCLES.
  - Enter RUN; busy goes high the following cycle.
- IDLE with start=1 and op=MTHI: hi<=src_a at the next edge, lo unchanged, no busy. MTLO likewise updates lo only.
- IDLE with start=1 and op=6..7: no effect.
- RUN:
  - cnt decrements every cycle.
  - When cnt==1: write the result into hi/lo at that edge, return to IDLE, and deassert busy the same edge.
  - Total time from the start edge to hi/lo valid is N cycles; mfhi in EX is correct on the cycle after busy falls.
- start=1 during RUN is ignored: no state change, no operand latch. The hazard unit guarantees this never occurs; the bench flags it as an error.
- stall_req = md_use_d & (busy | (start & op<=MD_DIVU)). The start term covers the cycle before busy rises. This signal is combinational from registers and inputs.
- Arithmetic, computed from the latched operands:
  - MULT: signed 32x32->64; hi=[63:32], lo=[31:0].
  - MULTU: the same, unsigned.
  - DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIV with 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - DIVU: unsigned quotient and remainder.
  - Divisor == 0 (DIV or DIVU): the unit still runs the full DIV_CYCLES, and hi/lo are left unchanged at completion.
- hi/lo change only at RUN completion, on MTHI/MTLO, or on reset. They hold their value in every other cycle.
- Outputs hi/lo/busy are registered; stall_req is the only combinational output.

Decomposition:
- macro.vh holds the MD_* opcode constants and the 3-bit MD op width macro. The controller decodes its md op and md_use signals from these.
- One combinational sub-module, md_calc, takes the latched op, a and b and produces the 64-bit {hi,lo} result plus a div_by_zero flag. md_unit instantiates it.
- The sequencer FSM, counter and HI/LO registers stay in md_unit.

Test Plan:
- mult: src_a=0xFFFFFFFE (-2), src_b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div: src_a=-7 (0xFFFFFFF9), src_b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 -> lo=3, hi=1; 0x80000000 / 0xFFFFFFFF (div) -> lo=0x80000000, hi=0.
- Divide by zero: hi=0x11, lo=0x22, then div with src_b=0 -> busy for 10 cycles; hi/lo remain 0x11/0x22.
- Stall: start a mult with md_use_d=1 held -> stall_req=1 on the start cycle and all 5 busy cycles, 0 on the cycle after busy falls; with md_use_d=0 -> stall_req stays 0 throughout.
- mthi/mtlo: mthi 0xDEADBEEF then mtlo 0x12345678 on consecutive cycles -> hi/lo update on the respective next edges; busy stays 0.
- Reset at cycle 3 of a div -> next edge gives busy=0, hi=lo=0, state=IDLE; a new mult started afterwards completes normally in 5 cycles.

Source files
------------

// File: rtl/md_unit_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding,
// sequencer states and small opcode-class helpers.
package md_unit_pkg;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Multi-cycle opcodes occupy the low end of the encoding
    function automatic logic is_long_op(input logic [MD_OP_W-1:0] op);
        return (op <= MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
        return (op <= MD_MULTU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational arithmetic core: 32x32 multiply and 32/32 divide on the
// operands latched by the sequencer. Division works on magnitudes and
// reapplies signs, which makes 0x80000000 / -1 fall out naturally.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [63:0]        result,
    output logic               div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] divisor;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo;
    logic [31:0] rem;

    // Products, magnitude division and sign fix-up, then select by opcode
    always_comb begin
        prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u  = {32'd0, a} * {32'd0, b};
        sdiv    = (op == MD_DIV);
        neg_a   = sdiv & a[31];
        neg_b   = sdiv & b[31];
        mag_a   = neg_a ? (32'd0 - a) : a;
        mag_b   = neg_b ? (32'd0 - b) : b;
        // A zero divisor is replaced so the divider never sees it;
        // the sequencer discards that result anyway.
        divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quo_u   = mag_a / divisor;
        rem_u   = mag_a % divisor;
        quo     = (neg_a ^ neg_b) ? (32'd0 - quo_u) : quo_u;
        rem     = neg_a ? (32'd0 - rem_u) : rem_u;

        div_by_zero = (op == MD_DIV || op == MD_DIVU) && (b == 32'd0);

        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV,
            MD_DIVU:  result = {rem, quo};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage: sequencer FSM, busy counter,
// architectural HI/LO registers and the stall request to the hazard unit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [MD_OP_W-1:0]  op,
    input  logic [31:0]         src_a,
    input  logic [31:0]         src_b,
    input  logic                md_use_d,
    output logic [31:0]         hi,
    output logic [31:0]         lo,
    output logic                busy,
    output logic                stall_req
);

    md_state_e          state_reg, state_next;
    logic [3:0]         cnt_reg;
    logic [31:0]        a_reg, b_reg;
    logic [MD_OP_W-1:0] op_reg;
    logic [31:0]        hi_reg, lo_reg;
    logic               busy_reg;

    logic               launch;
    logic               finish;
    logic               mthi_wr;
    logic               mtlo_wr;
    logic [63:0]        calc_result;
    logic               calc_div_by_zero;

    md_calc u_calc (
        .op          (op_reg),
        .a           (a_reg),
        .b           (b_reg),
        .result      (calc_result),
        .div_by_zero (calc_div_by_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state: leave IDLE on a multi-cycle op, return on the last count
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start && is_long_op(op)) state_next = ST_RUN;
            ST_RUN:  if (cnt_reg == 4'd1)         state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control strobes and the combinational stall request
    always_comb begin
        launch    = (state_reg == ST_IDLE) && start && is_long_op(op);
        finish    = (state_reg == ST_RUN) && (cnt_reg == 4'd1);
        mthi_wr   = (state_reg == ST_IDLE) && start && (op == MD_MTHI);
        mtlo_wr   = (state_reg == ST_IDLE) && start && (op == MD_MTLO);
        // start term covers the cycle before busy rises
        stall_req = md_use_d && (busy_reg || (start && is_long_op(op)));
    end

    // Operand latch, counter, busy flag and HI/LO write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg  <= 4'd0;
            a_reg    <= 32'd0;
            b_reg    <= 32'd0;
            op_reg   <= '0;
            hi_reg   <= 32'd0;
            lo_reg   <= 32'd0;
            busy_reg <= 1'b0;
        end else begin
            if (launch) begin
                a_reg    <= src_a;
                b_reg    <= src_b;
                op_reg   <= op;
                cnt_reg  <= is_mult_op(op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                busy_reg <= 1'b1;
            end else if (state_reg == ST_RUN) begin
                cnt_reg <= cnt_reg - 4'd1;
                if (finish) begin
                    busy_reg <= 1'b0;
                    // Division by zero leaves HI/LO as they were
                    if (!calc_div_by_zero) begin
                        hi_reg <= calc_result[63:32];
                        lo_reg <= calc_result[31:0];
                    end
                end
            end
            if (mthi_wr) hi_reg <= src_a;
            if (mtlo_wr) lo_reg <= src_a;
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = busy_reg;

endmodule
